fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DATASIZE, default 8: width of each write word.
REQ-002 Parameter DEPTH, default 8: memory entries, power of two and >= 2; ADDRSIZE = $clog2(DEPTH).
REQ-003 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-004 Port wclk  in  1: single clock, all logic on posedge.
REQ-005 Port wrst  in  1: reset, asynchronous, active-high.
REQ-006 Port req  in  NREQ: per-requester write request, level.
REQ-007 Port req_data  in  NREQ x DATASIZE: per-requester write word.
REQ-008 Port req_lock  in  NREQ: per-requester burst-lock request (used only with FIFO_ARB_LOCK_EN).
REQ-009 Port wr_full  in  1: FIFO full flag from write-side full logic.
REQ-010 Port gnt  out  NREQ: one-hot grant; data accepted in any cycle where gnt[i]=1.
REQ-011 Port wren  out  1: memory write enable, equals |gnt.
REQ-012 Port wdata  out  DATASIZE: req_data of the granted requester; 0 when wren=0.
REQ-013 Port waddr  out  ADDRSIZE: memory write address = wbin[ADDRSIZE-1:0].
REQ-014 Port wptr  out  ADDRSIZE+1: registered Gray-coded write pointer for the read-domain synchronizer.

Function
REQ-015 gnt, wren, wdata and waddr are combinational from the current state and inputs, so the write occurs in the grant cycle (zero latency).
REQ-016 No grant in any cycle where wr_full=1; requests stay pending, with no loss and no write.
REQ-017 Round-robin: the search starts at index (last+1) mod NREQ, where last is the most recently granted index; the first asserted req wins.
REQ-018 last updates on posedge only in cycles with a grant.
REQ-019 Internal binary pointer wbin (ADDRSIZE+1 bits) increments by 1 on posedge when wren=1, wrapping from 2^(ADDRSIZE+1)-1 to 0.
REQ-020 wptr <= bin2gray(next wbin) on the same edge, so wptr always equals bin2gray(wbin).
REQ-021 At most one gnt bit is set in any cycle; wren=1 implies wr_full=0.
REQ-022 A requester that continues to hold req receives back-to-back grants only when no other req is asserted (without lock).
REQ-023 With FIFO_ARB_LOCK_EN, the FSM has states IDLE and LOCKED; owner register is $clog2(NREQ) bits.
REQ-024 IDLE->LOCKED on a grant to i while req_lock[i]=1; owner<=i.
REQ-025 In LOCKED, only the owner is eligible and is granted every cycle while req[owner]=1 and wr_full=0; round-robin is bypassed.
REQ-026 LOCKED->IDLE on posedge when req[owner]=0 or req_lock[owner]=0, with no grant to owner in that cycle; the next cycle is round-robin from last=owner.
REQ-027 wr_full in LOCKED stalls the owner and keeps the state LOCKED.

Reset
REQ-028 On wrst=1, immediately: wbin=0, wptr=0, last=NREQ-1 (index 0 has first priority), state=IDLE, owner=0.
REQ-029 While wrst=1, gnt=0, wren=0 and wdata=0 regardless of req; reset mid-burst drops the lock with no write.

Configuration
REQ-030 Macro FIFO_ARB_LOCK_EN: when defined, REQ-023..REQ-027 apply; when undefined, req_lock is ignored, no FSM or owner register exists, and arbitration is pure round-robin.

Structure
REQ-031 Package pkg_graybin holds the bin2gray/gray2bin functions and the arb_state_t enum {IDLE, LOCKED}; ADDRSIZE is derived locally via $clog2.
REQ-032 Sub-module fifo_rr_pick: combinational round-robin picker (req, last -> one-hot gnt), instantiated once.

Verification
REQ-033 Reset, then req=4'b1111 with wr_full=0 for 4 cycles -> gnt 0001,0010,0100,1000; waddr 0,1,2,3; wptr 0->1->3->2->6.
REQ-034 req=4'b0101, wr_full=1 for 3 cycles then 0 -> no wren for 3 cycles, then gnt 0001 then 0100, with wdata matching each requester.
REQ-035 DEPTH=8, 16 consecutive writes -> waddr wraps 7->0 and wbin wraps 15->0, with wptr = Gray of wbin every cycle.
REQ-036 LOCK_EN: req[2]+req_lock[2] held 5 cycles while req=4'b1111 -> gnt 0100 five times; drop lock -> next gnt 1000.
REQ-037 LOCK_EN: wrst pulse in LOCKED during a burst -> gnt=0 at once, state IDLE, wptr=0, and first grant after reset goes to index 0.

Source files
------------

// File: rtl/pkg_graybin.sv
// pkg_graybin: Gray/binary pointer conversion helpers and the burst-lock arbiter state type
package pkg_graybin;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s <<= 1) b ^= b >> s;
    return b;
  endfunction
endpackage

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: combinational round-robin picker; req + last granted index -> one-hot gnt, search starts at last+1
module fifo_rr_pick #(
  parameter int NREQ = 4,
  localparam int LW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] gnt
);
  always_comb begin
    logic found;
    int idx;
    gnt = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin FIFO write arbiter (ports wclk, wrst, req, req_data, req_lock, wr_full -> gnt, wren, wdata, waddr, wptr); FIFO_ARB_LOCK_EN enables burst lock
module fifo_wr_arb
  import pkg_graybin::*;
#(
  parameter int DATASIZE = 8,
  parameter int DEPTH = 8,
  parameter int NREQ = 4,
  localparam int ADDRSIZE = $clog2(DEPTH),
  localparam int LW = $clog2(NREQ),
  localparam int PW = ADDRSIZE + 1
) (
  input  logic                               wclk,
  input  logic                               wrst,
  input  logic [NREQ-1:0]                    req,
  input  logic [NREQ-1:0][DATASIZE-1:0]      req_data,
  input  logic [NREQ-1:0]                    req_lock,
  input  logic                               wr_full,
  output logic [NREQ-1:0]                    gnt,
  output logic                               wren,
  output logic [DATASIZE-1:0]                wdata,
  output logic [ADDRSIZE-1:0]                waddr,
  output logic [PW-1:0]                      wptr
);
  logic [NREQ-1:0] rr_gnt, gnt_c;
  logic [LW-1:0] last, gidx;
  logic [PW-1:0] wbin, wbin_nxt;
  fifo_rr_pick #(.NREQ(NREQ)) u_pick (.req(req), .last(last), .gnt(rr_gnt));
`ifdef FIFO_ARB_LOCK_EN
  arb_state_t state, state_nxt;
  logic [LW-1:0] owner, owner_nxt;
  logic own_ok;
  assign own_ok = req[owner] && req_lock[owner];
  assign gnt_c = state == LOCKED ? (own_ok ? NREQ'(1) << owner : '0) : rr_gnt;
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    if (state == IDLE && wren && req_lock[gidx]) begin
      state_nxt = LOCKED;
      owner_nxt = gidx;
    end else if (state == LOCKED && !own_ok) state_nxt = IDLE;
  end
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
`else
  assign gnt_c = rr_gnt;
`endif
  assign gnt = (wrst || wr_full) ? '0 : gnt_c;
  assign wren = |gnt;
  assign waddr = wbin[ADDRSIZE-1:0];
  assign wbin_nxt = wbin + PW'(1);
  always_comb begin
    gidx = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        gidx = LW'(i);
        wdata = req_data[i];
      end
  end
  always_ff @(posedge wclk or posedge wrst)
    if (wrst) begin
      wbin <= '0;
      wptr <= '0;
      last <= LW'(NREQ - 1);
    end else if (wren) begin
      wbin <= wbin_nxt;
      wptr <= PW'(bin2gray(32'(wbin_nxt)));
      last <= gidx;
    end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: randomized scoreboard bench for fifo_wr_arb against a queue-based arbitration model
module tb_fifo_wr_arb;
  localparam int DW = 8, DEPTH = 8, N = 4;
  logic wclk = 1'b0, wrst = 1'b1, wr_full = 1'b0;
  logic [N-1:0] req = '0, req_lock = '0, gnt;
  logic [N-1:0][DW-1:0] req_data = '0;
  logic wren;
  logic [DW-1:0] wdata;
  logic [2:0] waddr;
  logic [3:0] wptr;
  typedef struct {int g; int d; int a; int p;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int last = N - 1, cnt = 0, owner = 0;
  bit locked = 0;

  fifo_wr_arb #(.DATASIZE(DW), .DEPTH(DEPTH), .NREQ(N)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .req_lock(req_lock),
    .wr_full(wr_full), .gnt(gnt), .wren(wren), .wdata(wdata), .waddr(waddr), .wptr(wptr)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] lk, input bit f, input bit rs);
    int g;
    bit ok;
    exp_t e;
    @(posedge wclk);
    #1;
    req = r;
    req_lock = lk;
    wr_full = f;
    wrst = rs;
    for (int i = 0; i < N; i++) req_data[i] = DW'($urandom);
    g = -1;
    ok = 0;
    if (rs) begin
      last = N - 1;
      cnt = 0;
      locked = 0;
      owner = 0;
    end
`ifdef FIFO_ARB_LOCK_EN
    else if (locked) begin
      ok = r[owner] && lk[owner];
      if (ok && !f) g = owner;
      if (!ok) locked = 0;
    end
`endif
    else if (!f)
      for (int k = 1; k <= N && g < 0; k++)
        if (r[(last + k) % N]) g = (last + k) % N;
`ifdef FIFO_ARB_LOCK_EN
    if (g >= 0 && !locked && lk[g]) begin
      locked = 1;
      owner = g;
    end
`endif
    e.g = g < 0 ? 0 : (1 << g);
    e.d = g < 0 ? 0 : int'(req_data[g]);
    e.a = cnt % DEPTH;
    e.p = cnt ^ (cnt >> 1);
    q.push_back(e);
    if (g >= 0) begin
      cnt = (cnt + 1) % (2 * DEPTH);
      last = g;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", int'(gnt), e.g);
        chk("wren", int'(wren), int'(e.g != 0));
        chk("wdata", int'(wdata), e.d);
        chk("waddr", int'(waddr), e.a);
        chk("wptr", int'(wptr), e.p);
      end
    end
  end

  initial begin
    repeat (2) step('0, '0, 0, 1);
    repeat (4) step(4'b1111, '0, 0, 0);
    step('0, '0, 0, 1);
    repeat (3) step(4'b0101, '0, 1, 0);
    repeat (2) step(4'b0101, '0, 0, 0);
    repeat (20) step(4'b1111, '0, 0, 0);
    step(4'b1111, '0, 0, 1);
    for (int i = 0; i < 300; i++)
      step(N'($urandom), N'($urandom), ($urandom % 4) == 0, ($urandom % 50) == 0);
`ifdef FIFO_ARB_LOCK_EN
    step('0, '0, 0, 1);
    repeat (7) step(4'b1111, 4'b0100, 0, 0);
    step(4'b1111, 4'b0100, 1, 0);
    step(4'b1111, '0, 0, 0);
    step(4'b1111, '0, 0, 0);
    step('0, '0, 0, 1);
    repeat (4) step(4'b1111, 4'b0100, 0, 0);
    step(4'b1111, 4'b0100, 0, 1);
    step(4'b1111, '0, 0, 0);
`endif
    repeat (3) @(negedge wclk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
